// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch push side, decode pop side, flush and occupancy.
// master = the fetch/decode environment, slave = the queue itself.
interface fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             flush;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular decoupling queue between fetch and decode with synchronous flush.
// FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming pair to decode combinationally.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, head_vld, byp;
  logic [63:0]      head;

  assign head_vld   = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  // in_ready is from registered state only, so fetch stall never sees out_ready.
  assign q.in_ready = (count_q != FULL_CNT);
  assign q.count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = ~head_vld & q.in_valid & ~q.flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed pair that decode takes immediately never occupies a slot.
  assign push = q.in_valid & q.in_ready & ~q.flush & ~(byp & q.out_ready);
  assign pop  = head_vld & q.out_ready & ~q.flush;

  always_comb begin
    q.out_valid = (head_vld & ~q.flush) | byp;
    q.out_pc    = 32'h0;
    q.out_instr = 32'h0;
    if (byp) begin
      q.out_pc    = q.in_pc;
      q.out_instr = q.in_instr;
    end else if (q.out_valid) begin
      q.out_pc    = head[63:32];
      q.out_instr = head[31:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q.in_pc, q.in_instr};
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling queue between the instruction fetch unit and the decode stage of the pipelined MIPS core. Accepts one {pc, instr} pair per cycle from fetch and presents them in order to decode with a valid/ready handshake. Its ready output drives the fetch stage's stall input. A flush discards all buffered and in-flight entries on a redirect.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- PTR_W, 2, log2(DEPTH); width of read/write pointers

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  queue can accept; fetch stall = ~in_ready
- in_pc  input  32  fetched PC
- in_instr  input  32  fetched instruction word
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  32  head PC
- out_instr  output  32  head instruction
- flush  input  1  synchronous discard of all entries
- count  output  PTR_W+1  number of stored entries, 0..DEPTH

## Operation
- Circular buffer: wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH), count register (PTR_W+1 bits).
- Push = in_valid & in_ready & ~flush: write {in_pc, in_instr} at wr_ptr, wr_ptr+1.
- Pop = out_valid & out_ready & ~flush: rd_ptr+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH). Registered-state-only; no combinational path from out_ready.
- out_valid = (count != 0) & ~flush.
- out_pc/out_instr = head entry when out_valid, else 32'h0 (masked, deterministic).
- flush: next edge sets count=0, wr_ptr=rd_ptr=0; push or pop in the flush cycle is discarded; flush has priority over everything except reset.
- Storage array is not reset; only pointers and count are reset.
- Full: in_ready=0 regardless of out_ready; fetch holds its PC via stall.
- Empty: out_valid=0, outputs 0.

## Timing
- Reset asserted (reset=0): immediately count=0, pointers 0, in_ready=1, out_valid=0, out_pc=out_instr=0.
- Reset deassertion is synchronous to clk externally; first push is accepted on the first rising edge with reset=1.
- Latency (macro off): pair pushed at edge k appears on out_* after edge k, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Full plus pop in the same cycle: pop occurs, count becomes DEPTH-1, in_ready rises the next cycle.
- Reset mid-operation discards all contents asynchronously.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and in_valid=1 and flush=0, out_valid=1 and out_pc/out_instr=in_pc/in_instr combinationally.
  - If out_ready=1 in that cycle, the pair is consumed and not written; count stays 0.
  - If out_ready=0, the pair is written normally.
  - Zero-cycle latency through an empty queue.
- Undefined: no in-to-out combinational path; minimum latency is one cycle as above.

## Test plan
- Reset, then push pc=0x3000..0x300C (instr 0x11111111..0x44444444) with out_ready=0 -> count=4, in_ready=0 after the 4th edge; a 5th pc=0x3010 is not accepted.
- From full, out_ready=1 for 4 cycles with in_valid=0 -> out_pc is 0x3000, 0x3004, 0x3008, 0x300C in order, then out_valid=0, out_pc=0, count=0.
- Continuous push and pop for 10 cycles from count=2 -> count stays 2; PCs emerge in order across pointer wrap.
- Queue holding 3 entries; flush=1 with in_valid=1 and out_ready=1 -> out_valid=0 in that cycle; next cycle count=0 and the in-flight pair is absent.
- Pull reset low mid-stream between edges -> count=0, out_valid=0, in_ready=1 before the next edge.
- Bypass: empty queue, in_valid=1 with pc=0x3020, out_ready=1.
  - With FETCH_QUEUE_BYPASS_EN: out_pc=0x3020 in the same cycle, count remains 0.
  - Without it: out_pc=0x3020 one cycle later.
